// File: rtl/decoder_stream.sv
// ============================================================================
// Module   : decoder_stream
// Brief    : Flow-controlled one-hot / thermometer decoder, 2-entry output FIFO
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_stream #(
    parameter int IN_W       = 3,
    parameter int NUM_OUT    = 8,
    parameter int ACTIVE_LOW = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_OUT-1:0]   out_data,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] C_ERR_MAX = '1;

    int                   code_int;
    logic [NUM_OUT-1:0]   dec_vec;
    logic                 dec_err;

    logic                 push;
    logic                 pop;

    logic [NUM_OUT-1:0]   head_vec_q, head_vec_d;
    logic                 head_err_q, head_err_d;
    logic [NUM_OUT-1:0]   tail_vec_q, tail_vec_d;
    logic                 tail_err_q, tail_err_d;
    logic [1:0]           count_q,    count_d;
    logic                 in_ready_q, in_ready_d;
    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    always_comb begin
        code_int = int'(in_code);
        dec_err  = (code_int >= NUM_OUT);
        dec_vec  = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            dec_vec[i] = in_mode ? (i <= code_int) : (i == code_int);
        end
        if (dec_err) begin
            dec_vec = '0;
        end
    end

    assign push = in_valid & in_ready_q;
    assign pop  = (count_q != 2'd0) & out_ready;

    // The head register doubles as the output register, so it naturally holds
    // the last popped beat once the FIFO drains.
    always_comb begin
        head_vec_d = head_vec_q;
        head_err_d = head_err_q;
        tail_vec_d = tail_vec_q;
        tail_err_d = tail_err_q;
        count_d    = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_vec_d = dec_vec;
                    head_err_d = dec_err;
                    count_d    = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_vec_d = dec_vec;
                    head_err_d = dec_err;
                end else if (push) begin
                    tail_vec_d = dec_vec;
                    tail_err_d = dec_err;
                    count_d    = 2'd2;
                end else if (pop) begin
                    count_d    = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_vec_d = tail_vec_q;
                    head_err_d = tail_err_q;
                    count_d    = 2'd1;
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
        in_ready_d = (count_d != 2'd2);
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (push && dec_err && (err_cnt_q != C_ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vec_q <= '0;
            head_err_q <= 1'b0;
            tail_vec_q <= '0;
            tail_err_q <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            err_cnt_q  <= '0;
        end else begin
            head_vec_q <= head_vec_d;
            head_err_q <= head_err_d;
            tail_vec_q <= tail_vec_d;
            tail_err_q <= tail_err_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_err   = head_err_q;
    assign err_cnt   = err_cnt_q;

    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign out_data = ~head_vec_q;
        end else begin : g_active_high
            assign out_data = head_vec_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_decoder_stream.sv
// ============================================================================
// Module   : tb_decoder_stream
// Brief    : Two parameterisations of decoder_stream against a queue model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_mode;
    logic       out_ready;
    logic       err_clr;

    logic       a_rdy, a_valid, a_err;
    logic [7:0] a_data;
    logic [7:0] a_cnt;
    logic       b_rdy, b_valid, b_err;
    logic [5:0] b_data;
    logic [1:0] b_cnt;

    always #5 clk = ~clk;

    decoder_stream #(.IN_W(3), .NUM_OUT(8), .ACTIVE_LOW(0), .ERR_CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_rdy),
        .in_code(in_code), .in_mode(in_mode), .out_valid(a_valid),
        .out_ready(out_ready), .out_data(a_data), .out_err(a_err),
        .err_clr(err_clr), .err_cnt(a_cnt)
    );

    decoder_stream #(.IN_W(3), .NUM_OUT(6), .ACTIVE_LOW(1), .ERR_CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_rdy),
        .in_code(in_code), .in_mode(in_mode), .out_valid(b_valid),
        .out_ready(out_ready), .out_data(b_data), .out_err(b_err),
        .err_clr(err_clr), .err_cnt(b_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: beats as (code*2 + mode) in a FIFO of depth two.
    int q[$];
    bit exp_rdy = 1'b1;
    int cnt_a   = 0;
    int cnt_b   = 0;
    bit last_push;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_vec(input int code, input int mode, input int n, input int al);
        int v;
        if (code >= n)     v = 0;
        else if (mode != 0) v = (1 << (code + 1)) - 1;
        else               v = 1 << code;
        if (al != 0) v = (~v) & ((1 << n) - 1);
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_rdy = 1'b1;
        cnt_a   = 0;
        cnt_b   = 0;
    endtask

    task automatic model_step();
        bit push, pop;
        int code;
        push = in_valid && exp_rdy;
        pop  = (q.size() != 0) && out_ready;
        code = int'(in_code);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(code * 2 + int'(in_mode));
        if (err_clr) begin
            cnt_a = 0;
            cnt_b = 0;
        end else if (push) begin
            if (code >= 8) cnt_a = (cnt_a < 255) ? cnt_a + 1 : 255;
            if (code >= 6) cnt_b = (cnt_b < 3) ? cnt_b + 1 : 3;
        end
        exp_rdy   = (q.size() < 2);
        last_push = push;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_valid", int'(a_valid), int'(q.size() != 0));
            chk("b_valid", int'(b_valid), int'(q.size() != 0));
            chk("a_ready", int'(a_rdy), int'(exp_rdy));
            chk("b_ready", int'(b_rdy), int'(exp_rdy));
            chk("a_errcnt", int'(a_cnt), cnt_a);
            chk("b_errcnt", int'(b_cnt), cnt_b);
            if (q.size() != 0) begin
                chk("a_data", int'(a_data), exp_vec(q[0] >> 1, q[0] & 1, 8, 0));
                chk("a_err",  int'(a_err),  int'((q[0] >> 1) >= 8));
                chk("b_data", int'(b_data), exp_vec(q[0] >> 1, q[0] & 1, 6, 1));
                chk("b_err",  int'(b_err),  int'((q[0] >> 1) >= 6));
            end
        end
    end

    // Accept one beat (in_ready is high on entry) and return at the negedge
    // after the accepting edge, while that beat is at the head.
    task automatic send1(input int code, input int mode);
        in_valid = 1'b1;
        in_code  = 3'(code);
        in_mode  = mode[0];
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_mode = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a_ready", int'(a_rdy), 1);
        chk("rst_a_valid", int'(a_valid), 0);
        chk("rst_a_data",  int'(a_data), 'h00);
        chk("rst_b_data",  int'(b_data), 'h3F);
        chk("rst_a_err",   int'(a_err), 0);
        chk("rst_b_cnt",   int'(b_cnt), 0);
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;

        out_ready = 1'b1;
        send1(0, 0); chk("t1_code0", int'(a_data), 'h01); tick();
        send1(3, 0); chk("t1_code3", int'(a_data), 'h08); tick();
        send1(7, 0); chk("t1_code7", int'(a_data), 'h80);
        chk("t1_err", int'(a_err), 0); tick();

        send1(4, 1);
        chk("t2_thermo", int'(a_data), 'h1F);
        chk("t2_thermo_al", int'(b_data), 'h20);
        tick();

        pulse_clr();
        send1(6, 0);
        chk("t3_code6_data", int'(b_data), 'h3F);
        chk("t3_code6_err", int'(b_err), 1);
        tick();
        send1(7, 0);
        chk("t3_code7_err", int'(b_err), 1);
        chk("t3_cnt2", int'(b_cnt), 2);
        tick();
        pulse_clr();
        chk("t3_clr", int'(b_cnt), 0);

        for (int i = 0; i < 5; i++) begin
            send1(6, 1);
            chk("t5_sat", int'(b_cnt), (i < 3) ? i + 1 : 3);
            tick();
        end
        in_valid = 1'b1; in_code = 3'd7; err_clr = 1'b1;
        tick();
        in_valid = 1'b0; err_clr = 1'b0;
        chk("t5_clr_wins", int'(b_cnt), 0);
        tick();

        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 1'b0;
        in_code = 3'd1; tick(); chk("t4_rdy1", int'(a_rdy), 1);
        in_code = 3'd2; tick(); chk("t4_rdy2", int'(a_rdy), 0);
        in_code = 3'd3; tick(); chk("t4_rdy3", int'(a_rdy), 0);
        chk("t4_head_held", int'(a_data), 'h02);
        out_ready = 1'b1;
        last_push = 1'b0;
        for (int i = 0; i < 10 && !last_push; i++) tick();
        chk("t4_third_accepted", int'(last_push), 1);
        in_valid = 1'b0;
        repeat (4) tick();

        out_ready = 1'b0;
        send1(6, 0);
        send1(7, 1);
        #2;
        rst_n  = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("t6_valid", int'(a_valid), 0);
        chk("t6_ready", int'(a_rdy), 1);
        chk("t6_b_cnt", int'(b_cnt), 0);
        chk("t6_b_data", int'(b_data), 'h3F);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t6_no_stale", int'(a_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_code   = 3'($urandom_range(0, 7));
            in_mode   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 40) == 0);
            tick();
        end
        in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
